board_matrix: RTL and testbench
===============================

# board_matrix

Parametrised Minesweeper board store, succeeding the fixed 8x8 zero-initialised matrix. It holds a ROWS x COLS array of 8-bit cells with mine, revealed, flag and neighbour-count fields. It accepts one command at a time over a valid/ready handshake: clear, place mine, reveal, toggle flag. It sits between the game controller FSM and the VGA/LED renderer, which reads the flattened board continuously.

## Interface
Parameters:
- ROWS, 8, board rows (2..16)
- COLS, 8, board columns (2..16)
- RW, $clog2(ROWS), row index width (localparam)
- CW, $clog2(COLS), column index width (localparam)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 CLEAR, 01 SET_MINE, 10 REVEAL, 11 FLAG
- cmd_row  in  RW  target row (ignored for CLEAR)
- cmd_col  in  CW  target column (ignored for CLEAR)
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse, coincident with done, for an out-of-range coordinate
- hit  out  1  sticky: a mined cell has been revealed
- mine_count  out  $clog2(ROWS*COLS+1)  mines currently placed
- board  out  [ROWS-1:0][COLS-1:0][7:0]  full cell array, registered

## Operation
- Cell byte: [7] mine, [6] revealed, [5] flagged, [4] reserved (always 0), [3:0] neighbour mine count (0..8).
- States: IDLE, CLEAR. cmd_ready = (state == IDLE). A command is accepted on valid & ready.
- CLEAR: go to CLEAR. Zero one row per cycle, starting at row 0. After row ROWS-1 is zeroed, return to IDLE. CLEAR also zeroes hit and mine_count.
- SET_MINE: single cycle.
  - If the cell is already a mine: no change.
  - Otherwise: set bit 7, increment [3:0] of every in-bounds neighbour (up to 8; edges and corners have fewer), and increment mine_count.
- REVEAL: single cycle.
  - Flagged or already revealed cell: no change.
  - Otherwise: set bit 6. If bit 7 is set, set hit.
- FLAG: single cycle. Toggle bit 5 unless the cell is revealed (then no change).
- Out-of-range coordinate (row ≥ ROWS or col ≥ COLS) on SET_MINE/REVEAL/FLAG: board unchanged; done and err pulse.
- Non-power-of-two ROWS/COLS must be handled. The index compare is done at full RW/CW width.

## Timing
- Reset values: board all zero, state IDLE, cmd_ready 1, done 0, err 0, hit 0, mine_count 0.
- Single-cycle ops:
  - Accepted at edge N; board, hit and mine_count update at edge N.
  - done is high during cycle N+1.
  - cmd_ready stays 1, so back-to-back commands are allowed every cycle.
- CLEAR:
  - Accepted at edge N.
  - cmd_ready is 0 from cycle N+1 through cycle N+ROWS.
  - Row r is zeroed at edge N+1+r.
  - done is high in cycle N+ROWS+1, with cmd_ready back to 1 in the same cycle.
- hit and mine_count clear at the first CLEAR sweep edge (N+1).
- Commands presented while cmd_ready is 0 are not accepted. cmd_valid may stay high; it is taken when ready returns.
- Reset asserted mid-CLEAR: immediate return to reset values; the partial sweep is abandoned.
- Neighbour count saturates at 8 by construction; no wrap.

## Structure
- Package board_pkg holds:
  - cmd_op enum (CMD_CLEAR, CMD_SET_MINE, CMD_REVEAL, CMD_FLAG).
  - Cell bit-position constants (MINE_B=7, REV_B=6, FLAG_B=5, CNT_MSB=3).
  - Packed cell_t struct.
  - State enum.
- Single module; no sub-module required. The neighbour-increment logic is a generate loop with bounds checks.

## Test plan
- Reset with ROWS=8, COLS=8 -> board all 0, cmd_ready=1, mine_count=0, hit=0.
- SET_MINE (0,0), then SET_MINE (1,1) -> cell(0,1) count 2, cell(1,0) count 2, cell(2,2) count 1, mine_count=2, done one cycle after each accept.
- FLAG (1,1), REVEAL (1,1) -> bit 5 set, reveal ignored, hit=0; FLAG again, then REVEAL (1,1) -> bit 6 set, hit=1.
- CLEAR after the above with cmd_valid held high for a following REVEAL -> cmd_ready low for 8 cycles, board zero, hit=0, then REVEAL accepted the cycle done pulses.
- ROWS=5, COLS=6: SET_MINE (5,0) -> done+err, board unchanged; SET_MINE (4,5) -> corner neighbours (3,4), (3,5), (4,4) count 1.
- Reset asserted at cycle 3 of a CLEAR -> all outputs at reset values immediately; next CLEAR completes normally.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types for the Minesweeper board store: command opcodes, cell layout
// and the sweep state machine encoding.
package board_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR    = 2'b00,
    CMD_SET_MINE = 2'b01,
    CMD_REVEAL   = 2'b10,
    CMD_FLAG     = 2'b11
  } cmd_op_e;

  // Bit positions inside one cell byte
  localparam int MINE_B  = 7;
  localparam int REV_B   = 6;
  localparam int FLAG_B  = 5;
  localparam int CNT_MSB = 3;

  typedef struct packed {
    logic             mine;
    logic             revealed;
    logic             flagged;
    logic             rsvd;
    logic [CNT_MSB:0] count;
  } cell_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/board_matrix.sv
// Parametrised Minesweeper board store. Single-cycle mine/reveal/flag
// commands update the registered cell array directly; CLEAR sweeps one row
// per cycle so the renderer never sees a wide one-shot reset.
module board_matrix
  import board_pkg::*;
#(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS),
  localparam int MCW  = $clog2(ROWS*COLS+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [RW-1:0]                 cmd_row,
  input  logic [CW-1:0]                 cmd_col,
  output logic                          done,
  output logic                          err,
  output logic                          hit,
  output logic [MCW-1:0]                mine_count,
  output logic [ROWS-1:0][COLS-1:0][7:0] board
);

  state_e                         state_q, state_d;
  logic [RW-1:0]                  clr_row_q;
  logic [ROWS-1:0][COLS-1:0][7:0] board_d;
  cmd_op_e                        op;
  cell_t                          tgt;
  logic                           accept, op_single, in_range, do_op;
  logic                           last_row, first_row;
  logic                           new_mine, do_reveal, do_flag;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign op_single = accept && (op != CMD_CLEAR);

  // Widened compare so non-power-of-two boards reject indices past the edge
  assign in_range  = ({1'b0, cmd_row} < (RW+1)'(ROWS)) &&
                     ({1'b0, cmd_col} < (CW+1)'(COLS));
  assign do_op     = op_single && in_range;

  assign last_row  = (clr_row_q == RW'(ROWS-1));
  assign first_row = (clr_row_q == '0);

  // Fetch the addressed cell without indexing past the array for bad coords
  always_comb begin
    tgt = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (cmd_row == RW'(r) && cmd_col == CW'(c)) begin
          tgt = cell_t'(board[r][c]);
        end
      end
    end
  end

  assign new_mine  = do_op && (op == CMD_SET_MINE) && !tgt.mine;
  assign do_reveal = do_op && (op == CMD_REVEAL) && !tgt.flagged && !tgt.revealed;
  assign do_flag   = do_op && (op == CMD_FLAG) && !tgt.revealed;

  // Per-cell next value: each cell decides whether it is the target or one
  // of its in-bounds neighbours, so edges and corners need no special case
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      cell_t cur, nxt;
      logic  is_tgt, is_nbr, row_near, col_near;

      assign cur      = cell_t'(board[r][c]);
      assign is_tgt   = (cmd_row == RW'(r)) && (cmd_col == CW'(c));
      assign row_near = (({1'b0, cmd_row} + (RW+1)'(1)) >= (RW+1)'(r)) &&
                        ({1'b0, cmd_row} <= (RW+1)'(r+1));
      assign col_near = (({1'b0, cmd_col} + (CW+1)'(1)) >= (CW+1)'(c)) &&
                        ({1'b0, cmd_col} <= (CW+1)'(c+1));
      assign is_nbr   = row_near && col_near && !is_tgt;

      // Apply the sweep or the accepted command to this one cell
      always_comb begin
        nxt = cur;
        if (state_q == ST_CLEAR) begin
          if (clr_row_q == RW'(r)) nxt = '0;
        end else begin
          if (new_mine && is_tgt)  nxt.mine     = 1'b1;
          if (new_mine && is_nbr)  nxt.count    = cur.count + 4'd1;
          if (do_reveal && is_tgt) nxt.revealed = 1'b1;
          if (do_flag && is_tgt)   nxt.flagged  = ~cur.flagged;
        end
      end

      assign board_d[r][c] = nxt;
    end
  end

  // Next-state logic: CLEAR runs until the last row has been zeroed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && op == CMD_CLEAR) state_d = ST_CLEAR;
      ST_CLEAR: if (last_row) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and sweep row pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_row_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR && !last_row) clr_row_q <= clr_row_q + 1'b1;
      else                                  clr_row_q <= '0;
    end
  end

  // Cell array register feeding the renderer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) board <= '0;
    else       board <= board_d;
  end

  // Completion pulses plus the sticky hit flag and mine tally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      err        <= 1'b0;
      hit        <= 1'b0;
      mine_count <= '0;
    end else begin
      done <= op_single || (state_q == ST_CLEAR && last_row);
      err  <= op_single && !in_range;
      if (state_q == ST_CLEAR && first_row) begin
        hit        <= 1'b0;
        mine_count <= '0;
      end else begin
        if (do_reveal && tgt.mine) hit        <= 1'b1;
        if (new_mine)              mine_count <= mine_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_matrix.sv
// Directed bench for board_matrix: an 8x8 instance for the main command set
// and a 5x6 instance for non-power-of-two bounds and corner neighbours.
module tb_board_matrix;
  import board_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  a_valid, a_ready, a_done, a_err, a_hit;
  logic [1:0]            a_op;
  logic [2:0]            a_row, a_col;
  logic [6:0]            a_mines;
  logic [7:0][7:0][7:0]  a_board;

  logic                  b_valid, b_ready, b_done, b_err, b_hit;
  logic [1:0]            b_op;
  logic [2:0]            b_row, b_col;
  logic [4:0]            b_mines;
  logic [4:0][5:0][7:0]  b_board;

  int checks = 0;
  int passes = 0;

  board_matrix #(.ROWS(8), .COLS(8)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_row(a_row), .cmd_col(a_col), .done(a_done),
    .err(a_err), .hit(a_hit), .mine_count(a_mines), .board(a_board)
  );

  board_matrix #(.ROWS(5), .COLS(6)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_row(b_row), .cmd_col(b_col), .done(b_done),
    .err(b_err), .hit(b_hit), .mine_count(b_mines), .board(b_board)
  );

  task automatic issue_a(input logic [1:0] op, input int r, input int c);
    @(negedge clk);
    a_valid = 1'b1; a_op = op; a_row = 3'(r); a_col = 3'(c);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] op, input int r, input int c);
    @(negedge clk);
    b_valid = 1'b1; b_op = op; b_row = 3'(r); b_col = 3'(c);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b0; a_op = 2'b00; a_row = '0; a_col = '0;
    b_valid = 1'b0; b_op = 2'b00; b_row = '0; b_col = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_board !== '0) $display("[TB] FAIL reset_board got %h want 0", a_board); else passes++;
    checks++; if (a_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", a_ready); else passes++;
    checks++; if (a_mines !== 7'd0) $display("[TB] FAIL reset_mines got %0d want 0", a_mines); else passes++;
    checks++; if (a_hit !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0)
      $display("[TB] FAIL reset_flags got hit=%b done=%b err=%b want 0 0 0", a_hit, a_done, a_err); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_set_mine();
    issue_a(CMD_SET_MINE, 0, 0);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0)
      $display("[TB] FAIL mine1_done got done=%b err=%b want 1 0", a_done, a_err); else passes++;
    issue_a(CMD_SET_MINE, 1, 1);
    checks++; if (a_done !== 1'b1) $display("[TB] FAIL mine2_done got %b want 1", a_done); else passes++;
    checks++; if (a_board[0][1] !== 8'h02) $display("[TB] FAIL cell01 got %h want 02", a_board[0][1]); else passes++;
    checks++; if (a_board[1][0] !== 8'h02) $display("[TB] FAIL cell10 got %h want 02", a_board[1][0]); else passes++;
    checks++; if (a_board[2][2] !== 8'h01) $display("[TB] FAIL cell22 got %h want 01", a_board[2][2]); else passes++;
    checks++; if (a_board[0][0] !== 8'h81) $display("[TB] FAIL cell00 got %h want 81", a_board[0][0]); else passes++;
    checks++; if (a_board[1][1] !== 8'h81) $display("[TB] FAIL cell11 got %h want 81", a_board[1][1]); else passes++;
    checks++; if (a_board[3][3] !== 8'h00) $display("[TB] FAIL cell33 got %h want 00", a_board[3][3]); else passes++;
    checks++; if (a_mines !== 7'd2) $display("[TB] FAIL mines2 got %0d want 2", a_mines); else passes++;
    issue_a(CMD_SET_MINE, 1, 1);
    checks++; if (a_mines !== 7'd2 || a_board[0][1] !== 8'h02)
      $display("[TB] FAIL remine got mines=%0d cell01=%h want 2 02", a_mines, a_board[0][1]); else passes++;
  endtask

  task automatic test_flag_reveal();
    issue_a(CMD_FLAG, 1, 1);
    checks++; if (a_board[1][1] !== 8'hA1) $display("[TB] FAIL flag_on got %h want A1", a_board[1][1]); else passes++;
    issue_a(CMD_REVEAL, 1, 1);
    checks++; if (a_board[1][1] !== 8'hA1 || a_hit !== 1'b0)
      $display("[TB] FAIL reveal_flagged got cell=%h hit=%b want A1 0", a_board[1][1], a_hit); else passes++;
    issue_a(CMD_FLAG, 1, 1);
    checks++; if (a_board[1][1] !== 8'h81) $display("[TB] FAIL flag_off got %h want 81", a_board[1][1]); else passes++;
    issue_a(CMD_REVEAL, 1, 1);
    checks++; if (a_board[1][1] !== 8'hC1 || a_hit !== 1'b1)
      $display("[TB] FAIL reveal_mine got cell=%h hit=%b want C1 1", a_board[1][1], a_hit); else passes++;
    issue_a(CMD_FLAG, 1, 1);
    checks++; if (a_board[1][1] !== 8'hC1 || a_done !== 1'b1)
      $display("[TB] FAIL flag_revealed got cell=%h done=%b want C1 1", a_board[1][1], a_done); else passes++;
  endtask

  task automatic test_clear_handoff();
    int low;
    low = 0;
    @(negedge clk);
    a_valid = 1'b1; a_op = CMD_CLEAR; a_row = '0; a_col = '0;
    @(posedge clk); #1;
    a_op = CMD_REVEAL; a_row = 3'd2; a_col = 3'd2;
    for (int i = 0; i < 20; i++) begin
      if (a_ready === 1'b1) break;
      low++;
      @(posedge clk); #1;
    end
    checks++; if (low != 8) $display("[TB] FAIL clear_busy got %0d want 8", low); else passes++;
    checks++; if (a_ready !== 1'b1 || a_done !== 1'b1)
      $display("[TB] FAIL clear_done got ready=%b done=%b want 1 1", a_ready, a_done); else passes++;
    checks++; if (a_board !== '0 || a_hit !== 1'b0 || a_mines !== 7'd0)
      $display("[TB] FAIL clear_state got hit=%b mines=%0d board_nonzero=%b want 0 0 0", a_hit, a_mines, a_board != '0); else passes++;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (a_board[2][2] !== 8'h40 || a_done !== 1'b1 || a_hit !== 1'b0)
      $display("[TB] FAIL handoff_reveal got cell=%h done=%b hit=%b want 40 1 0", a_board[2][2], a_done, a_hit); else passes++;
  endtask

  task automatic test_reset_mid_clear();
    int low;
    low = 0;
    issue_a(CMD_SET_MINE, 3, 3);
    issue_a(CMD_REVEAL, 3, 3);
    checks++; if (a_hit !== 1'b1 || a_mines !== 7'd1)
      $display("[TB] FAIL pre_clear got hit=%b mines=%0d want 1 1", a_hit, a_mines); else passes++;
    issue_a(CMD_CLEAR, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1 || a_done !== 1'b0)
      $display("[TB] FAIL midreset_ctrl got ready=%b done=%b want 1 0", a_ready, a_done); else passes++;
    checks++; if (a_board !== '0 || a_hit !== 1'b0 || a_mines !== 7'd0)
      $display("[TB] FAIL midreset_state got cell33=%h hit=%b mines=%0d want 00 0 0", a_board[3][3], a_hit, a_mines); else passes++;
    @(negedge clk);
    reset = 1'b0;
    issue_a(CMD_SET_MINE, 5, 5);
    checks++; if (a_mines !== 7'd1 || a_board[5][5] !== 8'h80)
      $display("[TB] FAIL post_reset_mine got mines=%0d cell=%h want 1 80", a_mines, a_board[5][5]); else passes++;
    issue_a(CMD_CLEAR, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (a_ready === 1'b1) break;
      low++;
      @(posedge clk); #1;
    end
    checks++; if (low != 8 || a_done !== 1'b1)
      $display("[TB] FAIL reclear got busy=%0d done=%b want 8 1", low, a_done); else passes++;
    checks++; if (a_board !== '0 || a_mines !== 7'd0)
      $display("[TB] FAIL reclear_state got cell55=%h mines=%0d want 00 0", a_board[5][5], a_mines); else passes++;
  endtask

  task automatic test_bounds_5x6();
    issue_b(CMD_SET_MINE, 5, 0);
    checks++; if (b_done !== 1'b1 || b_err !== 1'b1)
      $display("[TB] FAIL oob_row got done=%b err=%b want 1 1", b_done, b_err); else passes++;
    checks++; if (b_board !== '0 || b_mines !== 5'd0)
      $display("[TB] FAIL oob_row_state got mines=%0d board_nonzero=%b want 0 0", b_mines, b_board != '0); else passes++;
    issue_b(CMD_REVEAL, 0, 6);
    checks++; if (b_err !== 1'b1 || b_board !== '0)
      $display("[TB] FAIL oob_col got err=%b board_nonzero=%b want 1 0", b_err, b_board != '0); else passes++;
    issue_b(CMD_SET_MINE, 4, 5);
    checks++; if (b_done !== 1'b1 || b_err !== 1'b0 || b_mines !== 5'd1)
      $display("[TB] FAIL corner_mine got done=%b err=%b mines=%0d want 1 0 1", b_done, b_err, b_mines); else passes++;
    checks++; if (b_board[4][5] !== 8'h80) $display("[TB] FAIL corner45 got %h want 80", b_board[4][5]); else passes++;
    checks++; if (b_board[3][4] !== 8'h01 || b_board[3][5] !== 8'h01 || b_board[4][4] !== 8'h01)
      $display("[TB] FAIL corner_nbrs got %h %h %h want 01 01 01", b_board[3][4], b_board[3][5], b_board[4][4]); else passes++;
    checks++; if (b_board[4][3] !== 8'h00 || b_board[2][5] !== 8'h00)
      $display("[TB] FAIL corner_far got %h %h want 00 00", b_board[4][3], b_board[2][5]); else passes++;
  endtask

  initial begin
    test_reset();
    test_set_mine();
    test_flag_reveal();
    test_clear_handoff();
    test_reset_mid_clear();
    test_bounds_5x6();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
